// File: rtl/mem_responder.sv
// mem_responder
//   Word-addressed memory target for the multicycle CPU's request/ready
//   handshake. One access is in flight at a time. It is latched on accept,
//   held for WAIT_CYCLES wait states, performed, and then acknowledged with
//   a single-cycle ready pulse.
//
// Ports
//   clk    : system clock, rising-edge active
//   reset  : synchronous, active-high; aborts any in-flight access
//   req    : request valid, sampled only while idle
//   we     : 1 = write, 0 = read (latched with req)
//   addr   : word address (latched with req)
//   wdata  : write data (latched with req)
//   rdata  : registered read data, updated only on read completion
//   ready  : one-cycle completion pulse
//   busy   : high while an access is being served (WAIT or RESP)
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2    // 0..15, must fit the 4-bit wait counter
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              cnt;
  logic                    accept;
  logic                    do_access;

  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  // Storage powers up cleared; reset deliberately leaves it alone.
  logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: '0};

  // Next-state decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The access happens on the edge that leaves WAIT, so ready and
        // read data appear together in RESP.
        if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == ST_RESP);
      if (accept) begin
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access && !we_q) begin
        rdata <= mem[addr_q];
      end
    end
  end

  // Request capture: later changes on the inputs cannot affect the access.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Memory write; reset on the completing edge cancels it.
  always_ff @(posedge clk) begin
    if (!reset && do_access && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int W = 2;

  typedef struct {
    int          acc;
    logic [31:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready, busy;

  logic        req_s, we_s;
  logic [7:0]  addr_s;
  logic [31:0] wdata_s;
  logic [31:0] rd0, rd5;
  logic        rdy0, rdy5, busy0, busy5;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          idle_from = 0;

  exp_t        sb[$];
  logic [31:0] mem_m [256];
  logic [31:0] last_rd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy)
  );

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req(req_s), .we(we_s), .addr(addr_s),
    .wdata(wdata_s), .rdata(rd0), .ready(rdy0), .busy(busy0)
  );

  mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(5)) u_w5 (
    .clk(clk), .reset(reset), .req(req_s), .we(we_s), .addr(addr_s),
    .wdata(wdata_s), .rdata(rd5), .ready(rdy5), .busy(busy5)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (mon_en && ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ready_latency", 32'(cyc - e.acc), 32'(W + 1));
        chk("ready_rdata", rdata, e.rd);
        chk("ready_busy", 32'(busy), 32'd1);
      end
    end
  end

  // Issue one access on the main responder. With hold=1 req stays high after
  // ready so the next access follows back-to-back.
  task automatic issue(input bit w, input logic [7:0] a, input logic [31:0] d,
                       input bit hold, input bit perturb);
    exp_t e;
    bit   seen;
    e.acc = (idle_from > cyc + 1) ? idle_from : cyc + 1;
    idle_from = e.acc + W + 3;
    we = w; addr = a; wdata = d; req = 1'b1;
    if (w) mem_m[a] = d;
    else   last_rd = mem_m[a];
    e.rd = last_rd;
    sb.push_back(e);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (cyc == e.acc) begin
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (perturb) begin
          addr = a ^ 8'h01; we = ~w; wdata = ~d;
        end
      end
      if (ready) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 exp=1 (addr %h)", a);
    end
    if (!hold) req = 1'b0;
  endtask

  // Single-cycle request to the WAIT_CYCLES=0 and =5 instances; checks that
  // each gives exactly one ready pulse at the right distance from accept.
  task automatic sweep(input bit w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd);
    int          acc, f0, f5, n0, n5;
    logic [31:0] c0, c5;
    we_s = w; addr_s = a; wdata_s = d; req_s = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    req_s = 1'b0;
    f0 = -1; f5 = -1; n0 = 0; n5 = 0; c0 = '0; c5 = '0;
    for (int i = 0; i < 12; i++) begin
      if (rdy0) begin n0++; if (f0 < 0) begin f0 = cyc; c0 = rd0; end end
      if (rdy5) begin n5++; if (f5 < 0) begin f5 = cyc; c5 = rd5; end end
      @(negedge clk);
    end
    chk("w0_pulse_count", 32'(n0), 32'd1);
    chk("w0_latency", 32'(f0 - acc), 32'd1);
    chk("w5_pulse_count", 32'(n5), 32'd1);
    chk("w5_latency", 32'(f5 - acc), 32'd6);
    chk("w0_rdata", c0, exp_rd);
    chk("w5_rdata", c5, exp_rd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    bit          hold;
    logic [7:0]  a;
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    last_rd = '0;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req_s = 1'b0; we_s = 1'b0; addr_s = '0; wdata_s = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Write then read
    issue(1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    issue(1'b0, 8'h10, 32'h0, 1'b0, 1'b0);

    // Inputs changing while busy are ignored
    issue(1'b1, 8'h20, 32'h12345678, 1'b0, 1'b0);
    issue(1'b0, 8'h20, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 8'h21, 32'h0, 1'b0, 1'b0);

    // Highest and lowest addresses are distinct words
    issue(1'b1, 8'hFF, 32'hA5A5A5A5, 1'b0, 1'b0);
    issue(1'b1, 8'h00, 32'h5A5A5A5A, 1'b0, 1'b0);
    issue(1'b0, 8'hFF, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);

    // Reset on the edge that would complete a write
    @(negedge clk);
    addr = 8'h30; we = 1'b1; wdata = 32'hCAFEF00D; req = 1'b1;
    acc = cyc + 1;
    while (cyc < acc + W) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    @(negedge clk);
    chk("reset_with_req_busy", 32'(busy), 32'd0);
    reset = 1'b0; req = 1'b0;
    last_rd = '0;
    idle_from = 0;
    repeat (6) @(negedge clk);
    issue(1'b0, 8'h30, 32'h0, 1'b0, 1'b0);

    // Back-to-back reads with req held high
    for (int i = 0; i < 6; i++)
      issue(1'b0, (i % 2) ? 8'h10 : 8'h20, 32'h0, (i < 5), 1'b0);

    // Randomized traffic
    hold = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 3))
        0:       a = 8'h00;
        1:       a = 8'hFF;
        default: a = 8'h40 + 8'($urandom_range(0, 7));
      endcase
      hold = (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(1'($urandom_range(0, 1)), a, $urandom, hold, 1'b0);
    end

    // Wait-state sweep on the WAIT_CYCLES=0 and =5 instances
    @(negedge clk);
    sweep(1'b1, 8'h33, 32'h0BADF00D, 32'h0);
    sweep(1'b0, 8'h33, 32'h0, 32'h0BADF00D);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
